// File: rtl/mux_scan_capture.sv
// Scan controller for an IC74HC151 8:1 mux: walks every channel, samples Y after a
// settle delay, rebuilds the word and flags any channel where YF failed to be ~Y.
module mux_scan_capture #(
  parameter int unsigned DATA_SelectPart  = 3,
  parameter int unsigned DATA_Single_Part = 8,
  parameter int unsigned SETTLE_CYC       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        continuous,
  input  logic                        mux_y,
  input  logic                        mux_yf,
  output logic                        mux_en_n,
  output logic [DATA_SelectPart-1:0]  mux_sel,
  output logic [DATA_Single_Part-1:0] word,
  output logic                        word_valid,
  output logic                        busy,
  output logic                        err
);

  localparam int unsigned CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // With no settle delay each channel is a single SAMPLE cycle.
  localparam state_t S_FIRST = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;

  state_t                      r_state, w_state_nxt;
  logic                        r_en_n, w_en_n_nxt;
  logic [DATA_SelectPart-1:0]  r_sel, w_sel_nxt;
  logic [DATA_Single_Part-1:0] r_word, w_word_nxt;
  logic                        r_wv, w_wv_nxt;
  logic                        r_busy, w_busy_nxt;
  logic                        r_err, w_err_nxt;
  logic [DATA_Single_Part-1:0] r_shadow, w_shadow_nxt;
  logic                        r_err_acc, w_err_acc_nxt;
  logic [CW-1:0]               r_cnt, w_cnt_nxt;
  logic [DATA_Single_Part-1:0] w_shadow_cap;
  logic                        w_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_en_n    <= 1'b1;
      r_sel     <= '0;
      r_word    <= '0;
      r_wv      <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_shadow  <= '0;
      r_err_acc <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_en_n    <= w_en_n_nxt;
      r_sel     <= w_sel_nxt;
      r_word    <= w_word_nxt;
      r_wv      <= w_wv_nxt;
      r_busy    <= w_busy_nxt;
      r_err     <= w_err_nxt;
      r_shadow  <= w_shadow_nxt;
      r_err_acc <= w_err_acc_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_en_n_nxt    = r_en_n;
    w_sel_nxt     = r_sel;
    w_word_nxt    = r_word;
    w_wv_nxt      = 1'b0;
    w_busy_nxt    = r_busy;
    w_err_nxt     = r_err;
    w_shadow_nxt  = r_shadow;
    w_err_acc_nxt = r_err_acc;
    w_cnt_nxt     = r_cnt;
    w_bad         = (mux_yf == mux_y);
    w_shadow_cap  = r_shadow;
    w_shadow_cap[r_sel] = mux_y;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_FIRST;
          w_en_n_nxt    = 1'b0;
          w_sel_nxt     = '0;
          w_cnt_nxt     = '0;
          w_err_acc_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_shadow_nxt  = w_shadow_cap;
        w_err_acc_nxt = r_err_acc | w_bad;
        w_cnt_nxt     = '0;
        // Last channel publishes straight from the capture path so DONE already sees it.
        if (r_sel == '1) begin
          w_state_nxt = S_DONE;
          w_word_nxt  = w_shadow_cap;
          w_err_nxt   = r_err_acc | w_bad;
          w_wv_nxt    = 1'b1;
        end else begin
          w_sel_nxt   = r_sel + 1'b1;
          w_state_nxt = S_FIRST;
        end
      end
      S_DONE: begin
        w_sel_nxt = '0;
        w_cnt_nxt = '0;
        if (continuous) begin
          w_state_nxt   = S_FIRST;
          w_err_acc_nxt = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_en_n_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mux_en_n   = r_en_n;
  assign mux_sel    = r_sel;
  assign word       = r_word;
  assign word_valid = r_wv;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Bench for mux_scan_capture: two instances (settle 2 and settle 0), each driving a
// behavioural 74HC151 model; scan timelines are predicted from channel/settle arithmetic.
module tb_mux_scan_capture;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, cont_a = 1'b0, start_b = 1'b0, cont_b = 1'b0;
  logic       a_y, a_yf, a_en_n, a_wv, a_busy, a_err;
  logic       b_y, b_yf, b_en_n, b_wv, b_busy, b_err;
  logic [2:0] a_sel, b_sel;
  logic [7:0] a_word, b_word;
  logic [7:0] a_data = 8'h00, b_data = 8'h00;
  logic       a_bad_en = 1'b0, b_bad_en = 1'b0;
  logic [2:0] a_bad_ch = 3'd0, b_bad_ch = 3'd0;

  // 74HC151 model: Y low and W high while disabled; a fault can make W track Y.
  assign a_y  = a_en_n ? 1'b0 : a_data[a_sel];
  assign a_yf = (!a_en_n && a_bad_en && a_sel == a_bad_ch) ? a_y : ~a_y;
  assign b_y  = b_en_n ? 1'b0 : b_data[b_sel];
  assign b_yf = (!b_en_n && b_bad_en && b_sel == b_bad_ch) ? b_y : ~b_y;

  mux_scan_capture #(.DATA_SelectPart(3), .DATA_Single_Part(8), .SETTLE_CYC(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .continuous(cont_a),
    .mux_y(a_y), .mux_yf(a_yf), .mux_en_n(a_en_n), .mux_sel(a_sel),
    .word(a_word), .word_valid(a_wv), .busy(a_busy), .err(a_err));

  mux_scan_capture #(.DATA_SelectPart(3), .DATA_Single_Part(8), .SETTLE_CYC(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .continuous(cont_b),
    .mux_y(b_y), .mux_yf(b_yf), .mux_en_n(b_en_n), .mux_sel(b_sel),
    .word(b_word), .word_valid(b_wv), .busy(b_busy), .err(b_err));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned f_sel(input int which);
    return (which != 0) ? 32'(b_sel) : 32'(a_sel);
  endfunction
  function automatic int unsigned f_en(input int which);
    return (which != 0) ? 32'(b_en_n) : 32'(a_en_n);
  endfunction
  function automatic int unsigned f_wv(input int which);
    return (which != 0) ? 32'(b_wv) : 32'(a_wv);
  endfunction
  function automatic int unsigned f_busy(input int which);
    return (which != 0) ? 32'(b_busy) : 32'(a_busy);
  endfunction
  function automatic int unsigned f_word(input int which);
    return (which != 0) ? 32'(b_word) : 32'(a_word);
  endfunction
  function automatic int unsigned f_err(input int which);
    return (which != 0) ? 32'(b_err) : 32'(a_err);
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which != 0) start_b = v;
    else            start_a = v;
  endtask

  task automatic chk_reset_state(input int which, input string tag);
    chk({tag, "_en_n"}, f_en(which), 1);
    chk({tag, "_sel"},  f_sel(which), 0);
    chk({tag, "_word"}, f_word(which), 0);
    chk({tag, "_wv"},   f_wv(which), 0);
    chk({tag, "_busy"}, f_busy(which), 0);
    chk({tag, "_err"},  f_err(which), 0);
  endtask

  // Single scan: channel c is selected for settle+1 cycles starting at c*(settle+1)
  // after the start edge; the word appears N*(settle+1) cycles after that edge.
  task automatic run_scan(input int which, input int unsigned s, input logic [7:0] data,
                          input logic bad_en, input int unsigned bad_ch,
                          input logic [7:0] exp_word, input logic exp_err);
    int unsigned len;
    len = N * (s + 1);
    if (which != 0) begin
      b_data = data; b_bad_en = bad_en; b_bad_ch = 3'(bad_ch);
    end else begin
      a_data = data; a_bad_en = bad_en; a_bad_ch = 3'(bad_ch);
    end
    set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
    chk("scan_busy", f_busy(which), 1);
    chk("scan_en_n", f_en(which), 0);
    for (int unsigned k = 0; k < len; k++) begin
      chk("scan_sel", f_sel(which), k / (s + 1));
      chk("scan_nowv", f_wv(which), 0);
      tick();
    end
    chk("scan_wv", f_wv(which), 1);
    chk("scan_word", f_word(which), 32'(exp_word));
    chk("scan_err", f_err(which), 32'(exp_err));
    chk("scan_done_busy", f_busy(which), 1);
    tick();
    chk("post_wv", f_wv(which), 0);
    chk("post_busy", f_busy(which), 0);
    chk("post_en_n", f_en(which), 1);
    chk("post_sel", f_sel(which), 0);
    chk("post_word_hold", f_word(which), 32'(exp_word));
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        bad_en;
    int unsigned bad_ch;
    logic [7:0]  exp_word;
    logic        exp_err;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #200us;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'hBD, 1'b0, 5, 8'hBD, 1'b0};
    tbl[1] = '{8'hBD, 1'b1, 5, 8'hBD, 1'b1};
    tbl[2] = '{8'hBD, 1'b0, 5, 8'hBD, 1'b0};
    tbl[3] = '{8'h42, 1'b1, 0, 8'h42, 1'b1};
    tbl[4] = '{8'hFF, 1'b1, 7, 8'hFF, 1'b1};
    tbl[5] = '{8'h01, 1'b0, 3, 8'h01, 1'b0};

    #2 rst = 1'b1;
    #1;
    chk_reset_state(0, "rst_a");
    chk_reset_state(1, "rst_b");
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_reset_state(0, "idle_a");

    // Table-driven single scans on both instances
    for (int i = 0; i < 6; i++)
      run_scan(0, 2, tbl[i].data, tbl[i].bad_en, tbl[i].bad_ch, tbl[i].exp_word, tbl[i].exp_err);
    for (int i = 0; i < 6; i++)
      run_scan(1, 0, tbl[i].data, tbl[i].bad_en, tbl[i].bad_ch, tbl[i].exp_word, tbl[i].exp_err);

    // Randomized scans: captured word equals mux inputs, err equals presence of a fault
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  d;
      logic        be;
      int unsigned bc;
      d  = 8'($urandom);
      be = 1'($urandom_range(0, 1));
      bc = $urandom_range(0, 7);
      run_scan(i % 2, (i % 2 != 0) ? 0 : 2, d, be, bc, d, be);
    end

    // Continuous mode: period N*(settle+1)+1, data change after ch7 shows in next word
    a_data = 8'hBD; a_bad_en = 1'b0;
    cont_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      if (k == 24) begin
        chk("cont_wv1", 32'(a_wv), 1);
        chk("cont_word1", 32'(a_word), 32'hBD);
        a_data = 8'h42;
      end else if (k == 49) begin
        chk("cont_wv2", 32'(a_wv), 1);
        chk("cont_word2", 32'(a_word), 32'h42);
        cont_a = 1'b0;
      end else if (k == 50) begin
        chk("cont_stop_wv", 32'(a_wv), 0);
        chk("cont_stop_busy", 32'(a_busy), 0);
        chk("cont_stop_en_n", 32'(a_en_n), 1);
      end else begin
        chk("cont_nowv", 32'(a_wv), 0);
        chk("cont_busy", 32'(a_busy), 1);
        if (k == 25) begin
          chk("cont_rescan_sel", 32'(a_sel), 0);
          chk("cont_rescan_en_n", 32'(a_en_n), 0);
        end
      end
      if (k < 50) tick();
    end

    // Start re-pulse mid-scan is ignored; reset at ch4 aborts with no pulse
    a_data = 8'hBD;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int unsigned k = 0; k <= 12; k++) begin
      chk("repulse_sel", 32'(a_sel), k / 3);
      start_a = (k == 9);
      if (k < 12) tick();
    end
    start_a = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_state(0, "abort");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("abort_nowv", 32'(a_wv), 0);
      chk("abort_idle", 32'(a_busy), 0);
    end
    chk("abort_word", 32'(a_word), 0);

    // Reset mid-operation on the settle-0 instance
    b_data = 8'hBD;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    tick();
    chk("mid_sel_b", 32'(b_sel), 2);
    #2 rst = 1'b1;
    #1;
    chk_reset_state(1, "mid_rst_b");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("mid_nowv_b", 32'(b_wv), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
